// File: rtl/ai_accelerator_pkg.sv
// Shared types and sizing constants for the conv2d accelerator datapath.
// The window buffer and the conv2d engine both import this package.
package ai_accelerator_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int FILTER_SIZE  = 3;
  localparam int RESULT_WIDTH = 2 * DATA_WIDTH + 4;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  // Indexed [row][col]; [0][0] is the oldest (top-left) pixel of the window.
  typedef pixel_t [FILTER_SIZE-1:0][FILTER_SIZE-1:0] patch_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-stream input and window output handshakes of the window buffer.
// The master side is the pixel source plus window consumer; the slave side is the buffer.
interface conv_window_buffer_if #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
);
  import ai_accelerator_pkg::*;

  localparam int ROW_W = idx_width(IMG_HEIGHT);
  localparam int COL_W = idx_width(IMG_WIDTH);

  logic             pix_valid;
  pixel_t           pix_data;
  logic             pix_ready;
  logic             win_valid;
  logic             win_ready;
  patch_t           image_patch;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;

  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, image_patch, win_row, win_col, frame_done
  );

  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, image_patch, win_row, win_col, frame_done
  );

endinterface

// File: rtl/conv_window_buffer_line_buffer.sv
// Enable-driven delay of exactly DEPTH accepted pixels: a DEPTH-1 entry RAM
// plus its registered read port, so dout is a plain register output.
module line_buffer
  import ai_accelerator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout
);

  localparam int MEM_DEPTH = DEPTH - 1;
  localparam int PTR_W     = idx_width(MEM_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);

  pixel_t           mem [MEM_DEPTH];
  pixel_t           rd_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (en) begin
      ptr_next = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Storage is left unreset; stale data never reaches a valid window.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_reg        <= mem[ptr_reg];
      mem[ptr_reg]  <= din;
    end
  end

  assign dout = rd_reg;

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding FILTER_SIZE x FILTER_SIZE window generator over a raster pixel stream,
// emitting only fully-inside (valid-convolution) windows with their coordinates.
module conv_window_buffer
  import ai_accelerator_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_buffer_if.slave bus
);

  localparam int ROW_W = idx_width(IMG_HEIGHT);
  localparam int COL_W = idx_width(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_OFF  = ROW_W'(FILTER_SIZE - 1);
  localparam logic [COL_W-1:0] COL_OFF  = COL_W'(FILTER_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - FILTER_SIZE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - FILTER_SIZE);

  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] win_row_reg;
  logic [COL_W-1:0] win_col_reg;
  logic             win_valid_reg;
  patch_t           patch_reg;

  logic   pix_ready;
  logic   accept;
  logic   window_done;
  pixel_t lb_in   [FILTER_SIZE-1];
  pixel_t lb_out  [FILTER_SIZE-1];
  pixel_t new_col [FILTER_SIZE];

  assign pix_ready   = !win_valid_reg || bus.win_ready;
  assign accept      = bus.pix_valid && pix_ready;
  assign window_done = (row_reg >= ROW_OFF) && (col_reg >= COL_OFF);

  // Line buffer gi holds rows delayed by gi+1; the oldest row lands at the top of the window.
  assign lb_in[0] = bus.pix_data;
  for (genvar gi = 1; gi < FILTER_SIZE - 1; gi++) begin : g_chain
    assign lb_in[gi] = lb_out[gi-1];
  end

  for (genvar gi = 0; gi < FILTER_SIZE - 1; gi++) begin : g_line
    line_buffer #(
      .DEPTH (IMG_WIDTH)
    ) u_line_buffer (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (lb_in[gi]),
      .dout (lb_out[gi])
    );
    assign new_col[gi] = lb_out[FILTER_SIZE-2-gi];
  end
  assign new_col[FILTER_SIZE-1] = bus.pix_data;

  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (accept) begin
      if (col_reg == COL_MAX) begin
        col_next = '0;
        row_next = (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg       <= '0;
      col_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
      patch_reg     <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
      if (accept) begin
        for (int r = 0; r < FILTER_SIZE; r++) begin
          for (int c = 0; c < FILTER_SIZE - 1; c++) begin
            patch_reg[r][c] <= patch_reg[r][c+1];
          end
          patch_reg[r][FILTER_SIZE-1] <= new_col[r];
        end
      end
      // Accept is only possible once any held window is consumed, so loading wins over clearing.
      if (accept && window_done) begin
        win_valid_reg <= 1'b1;
        win_row_reg   <= row_reg - ROW_OFF;
        win_col_reg   <= col_reg - COL_OFF;
      end else if (bus.win_ready) begin
        win_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.pix_ready   = pix_ready;
  assign bus.win_valid   = win_valid_reg;
  assign bus.image_patch = patch_reg;
  assign bus.win_row     = win_row_reg;
  assign bus.win_col     = win_col_reg;
  assign bus.frame_done  = win_valid_reg && bus.win_ready &&
                           (win_row_reg == ROW_LAST) && (win_col_reg == COL_LAST);

endmodule
